// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared constants and types for the ALU request sequencer:
//            ALU op codes, flag bit positions, FSM state encoding, the
//            response payload type and a small one-hot helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   // ALU operation codes
   localparam logic [1:0] OP_ADD     = 2'd0;
   localparam logic [1:0] OP_SUB     = 2'd1;
   localparam logic [1:0] OP_LOGIC_A = 2'd2;
   localparam logic [1:0] OP_LOGIC_B = 2'd3;

   // Bit positions inside the 5-bit flag vector {par, ovf, gt, eq, less}
   localparam int FLG_LESS = 0;
   localparam int FLG_EQ   = 1;
   localparam int FLG_GT   = 2;
   localparam int FLG_OVF  = 3;
   localparam int FLG_PAR  = 4;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } seq_state_e;

   // Result and flags captured from the ALU. The tag width is chosen per
   // instance, so the tag is appended next to this struct in the FIFO word.
   typedef struct packed {
      logic [7:0] y;
      logic [4:0] flags;
   } alu_res_t;

   // True when exactly one of the three compare flags is set
   function automatic logic onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_req_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_sequencer_if
// Brief    : Request, ALU-drive and response bundle of the ALU sequencer.
//            master = sequencer side, slave = requester/ALU/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_req_sequencer_if #(
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [7:0]       req_a;
   logic [7:0]       req_b;
   logic [1:0]       req_op;
   logic [TAG_W-1:0] req_tag;

   logic [7:0]       alu_a;
   logic [7:0]       alu_b;
   logic [1:0]       alu_op;
   logic [7:0]       alu_y;
   logic [4:0]       alu_flags;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_y;
   logic [4:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      input  req_valid, req_a, req_b, req_op, req_tag,
      output req_ready,
      output alu_a, alu_b, alu_op,
      input  alu_y, alu_flags,
      output rsp_valid, rsp_y, rsp_flags, rsp_tag,
      input  rsp_ready
   );

   modport slave (
      output req_valid, req_a, req_b, req_op, req_tag,
      input  req_ready,
      input  alu_a, alu_b, alu_op,
      output alu_y, alu_flags,
      input  rsp_valid, rsp_y, rsp_flags, rsp_tag,
      output rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_rsp_fifo
// Brief    : First-word-fall-through FIFO. data_o shows the head entry;
//            while empty it keeps showing the most recently popped word.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4      // power of two, >= 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic [WIDTH-1:0] last_q;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign data_o  = empty_o ? last_q : mem_q[rd_q];

   // Storage array, written at the tail on push
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= push_data_i;
   end

   // Pointers, occupancy and last-popped word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) begin
            rd_q   <= rd_q + 1'b1;
            last_q <= mem_q[rd_q];
         end
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/alu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_sequencer
// Brief    : Accepts ALU requests, holds operands for SETTLE_CYC cycles,
//            captures result/flags/tag into a response FIFO, and keeps a
//            sticky overflow bit and a completed-operation counter.
//            Optional macro ALU_CHECK_EN adds the chk_err consistency check.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_sequencer
   import alu_seq_pkg::*;
#(
   parameter int TAG_W      = 4,   // must match the interface TAG_W
   parameter int SETTLE_CYC = 2,   // 1..15
   parameter int RSP_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_req_sequencer_if.master  bus,
   input  logic                 clr_sticky,
   output logic                 sticky_ovf,
   output logic [15:0]          op_cnt,
   output logic                 busy
`ifdef ALU_CHECK_EN
   ,
   output logic                 chk_err
`endif
);
   localparam logic [1:0] S_IDLE    = 2'(IDLE);
   localparam logic [1:0] S_SETTLE  = 2'(SETTLE);
   localparam logic [1:0] S_CAPTURE = 2'(CAPTURE);
   localparam int         FIFO_W    = $bits(alu_res_t) + TAG_W;

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             rdy_en_q;
   logic             sticky_q, sticky_d;
   logic [15:0]      ops_q, ops_d;

   logic              fifo_full, fifo_empty;
   logic              accept, push, pop;
   alu_res_t          cap_res, head_res;
   logic [FIFO_W-1:0] head_data;

   // rdy_en_q keeps req_ready low throughout reset and for the first edge after
   assign bus.req_ready = rdy_en_q && (state_q == S_IDLE) && !fifo_full;
   assign accept        = bus.req_valid && bus.req_ready;
   assign push          = (state_q == S_CAPTURE);
   assign pop           = bus.rsp_valid && bus.rsp_ready;
   assign busy          = (state_q != S_IDLE);

   assign bus.alu_a  = a_q;
   assign bus.alu_b  = b_q;
   assign bus.alu_op = op_q;
   assign sticky_ovf = sticky_q;
   assign op_cnt     = ops_q;

   assign cap_res.y     = bus.alu_y;
   assign cap_res.flags = bus.alu_flags;

   // Next-state logic: FSM, operand latches, counters and sticky status
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      tag_d    = tag_q;
      ops_d    = ops_q;
      sticky_d = clr_sticky ? 1'b0 : sticky_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               op_d    = bus.req_op;
               tag_d   = bus.req_tag;
               cnt_d   = 4'(SETTLE_CYC - 1);
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == 4'd0) state_d = S_CAPTURE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_CAPTURE: begin
            ops_d   = ops_q + 16'd1;
            if (bus.alu_flags[FLG_OVF]) sticky_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         tag_q    <= '0;
         rdy_en_q <= 1'b0;
         sticky_q <= 1'b0;
         ops_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         rdy_en_q <= 1'b1;
         sticky_q <= sticky_d;
         ops_q    <= ops_d;
      end
   end

   alu_rsp_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i ({cap_res, tag_q}),
      .pop_i       (pop),
      .data_o      (head_data),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign {head_res, bus.rsp_tag} = head_data;
   assign bus.rsp_y     = head_res.y;
   assign bus.rsp_flags = head_res.flags;
   assign bus.rsp_valid = !fifo_empty;

`ifdef ALU_CHECK_EN
   logic chk_q, chk_bad;

   assign chk_bad = !onehot3(bus.alu_flags[FLG_GT:FLG_LESS]) ||
                    (bus.alu_flags[FLG_EQ] != (a_q == b_q));
   assign chk_err = chk_q;

   // Sticky consistency error; a capture-time error beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 chk_q <= 1'b0;
      else if (push && chk_bad)   chk_q <= 1'b1;
      else if (clr_sticky)        chk_q <= 1'b0;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_sequencer
// Brief    : Directed self-checking bench for alu_req_sequencer with a
//            behavioural stub ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_sticky;
   logic        sticky_ovf;
   logic [15:0] op_cnt;
   logic        busy;
`ifdef ALU_CHECK_EN
   logic        chk_err;
`endif
   logic        force_bad;
   logic [7:0]  stub_y;
   logic        stub_ovf;
   int          checks = 0;
   int          errors = 0;

   alu_req_sequencer_if #(.TAG_W(4)) bus ();

   alu_req_sequencer #(
      .TAG_W      (4),
      .SETTLE_CYC (2),
      .RSP_DEPTH  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .clr_sticky (clr_sticky),
      .sticky_ovf (sticky_ovf),
      .op_cnt     (op_cnt),
      .busy       (busy)
`ifdef ALU_CHECK_EN
      ,
      .chk_err    (chk_err)
`endif
   );

   always #5 clk = ~clk;

   // Stub ALU: add/sub with signed overflow, and/or, unsigned compares
   always_comb begin
      stub_y   = 8'h00;
      stub_ovf = 1'b0;
      case (bus.alu_op)
         2'd0: begin
            stub_y   = bus.alu_a + bus.alu_b;
            stub_ovf = (bus.alu_a[7] == bus.alu_b[7]) && (stub_y[7] != bus.alu_a[7]);
         end
         2'd1: begin
            stub_y   = bus.alu_a - bus.alu_b;
            stub_ovf = (bus.alu_a[7] != bus.alu_b[7]) && (stub_y[7] != bus.alu_a[7]);
         end
         2'd2:    stub_y = bus.alu_a & bus.alu_b;
         default: stub_y = bus.alu_a | bus.alu_b;
      endcase
   end
   assign bus.alu_y     = stub_y;
   assign bus.alu_flags = {^stub_y, stub_ovf, (bus.alu_a > bus.alu_b) | force_bad,
                           bus.alu_a == bus.alu_b, bus.alu_a < bus.alu_b};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait (bounded) for req_ready, return after the accept edge
   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [3:0] tag);
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_op    = op;
      bus.req_tag   = tag;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("req_ready_wait", bus.req_ready, 1'b1);
      tick();
      bus.req_valid = 1'b0;
   endtask

   // Full operation: returns just after the capture edge
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [3:0] tag);
      send(a, b, op, tag);
      repeat (3) tick();
   endtask

   task automatic pop_one();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      clr_sticky    = 1'b0;
      force_bad     = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_a     = 8'h00;
      bus.req_b     = 8'h00;
      bus.req_op    = 2'd0;
      bus.req_tag   = 4'h0;
      bus.rsp_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_req_ready", bus.req_ready, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_busy",      busy, 1'b0);
      check("rst_op_cnt",    op_cnt, 16'd0);
      check("rst_sticky",    sticky_ovf, 1'b0);
      check("rst_alu_a",     bus.alu_a, 8'h00);
      check("rst_rsp_y",     bus.rsp_y, 8'h00);
`ifdef ALU_CHECK_EN
      check("rst_chk_err",   chk_err, 1'b0);
`endif
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", bus.req_ready, 1'b0);
      tick();
      check("ready_after_rst", bus.req_ready, 1'b1);
      check("idle_rsp_valid",  bus.rsp_valid, 1'b0);

      // Single op: 5 + 5 = 0x0A, equal flag only
      bus.req_valid = 1'b1;
      bus.req_a     = 8'h05;
      bus.req_b     = 8'h05;
      bus.req_op    = 2'd0;
      bus.req_tag   = 4'h3;
      tick();
      bus.req_valid = 1'b0;
      bus.req_a     = 8'hFF;
      bus.req_b     = 8'hEE;
      check("s1_busy",      busy, 1'b1);
      check("s1_ready_low", bus.req_ready, 1'b0);
      check("s1_alu_a_c0",  bus.alu_a, 8'h05);
      check("s1_alu_b_c0",  bus.alu_b, 8'h05);
      tick();
      check("s1_alu_a_c1",  bus.alu_a, 8'h05);
      check("s1_alu_b_c1",  bus.alu_b, 8'h05);
      check("s1_rsp_early1", bus.rsp_valid, 1'b0);
      tick();
      check("s1_rsp_early2", bus.rsp_valid, 1'b0);
      check("s1_busy_cap",   busy, 1'b1);
      tick();
      check("s1_rsp_valid", bus.rsp_valid, 1'b1);
      check("s1_rsp_y",     bus.rsp_y, 8'h0A);
      check("s1_rsp_flags", bus.rsp_flags, 5'b00010);
      check("s1_rsp_tag",   bus.rsp_tag, 4'h3);
      check("s1_op_cnt",    op_cnt, 16'd1);
      check("s1_busy_done", busy, 1'b0);
      check("s1_sticky",    sticky_ovf, 1'b0);
      pop_one();
      check("s1_popped",    bus.rsp_valid, 1'b0);
      check("s1_hold_y",    bus.rsp_y, 8'h0A);
      check("s1_alu_kept",  bus.alu_a, 8'h05);

      // Backpressure: fill the 4-entry FIFO, fifth request must stall
      for (int i = 0; i < 4; i++) send(8'(i), 8'h10, 2'd0, 4'(i));
      repeat (3) tick();
      check("bp_op_cnt", op_cnt, 16'd5);
      bus.req_valid = 1'b1;
      bus.req_a     = 8'h04;
      bus.req_b     = 8'h10;
      bus.req_op    = 2'd0;
      bus.req_tag   = 4'h4;
      repeat (6) tick();
      check("bp_full_ready", bus.req_ready, 1'b0);
      check("bp_full_busy",  busy, 1'b0);
      check("bp_op_cnt_hold", op_cnt, 16'd5);
      bus.rsp_ready = 1'b1;
      check("bp_tag0", bus.rsp_tag, 4'h0);
      check("bp_y0",   bus.rsp_y, 8'h10);
      tick();
      check("bp_ready_after_pop", bus.req_ready, 1'b1);
      check("bp_tag1", bus.rsp_tag, 4'h1);
      tick();
      bus.req_valid = 1'b0;
      check("bp_fifth_busy", busy, 1'b1);
      check("bp_tag2", bus.rsp_tag, 4'h2);
      check("bp_y2",   bus.rsp_y, 8'h12);
      tick();
      check("bp_tag3", bus.rsp_tag, 4'h3);
      tick();
      check("bp_empty",    bus.rsp_valid, 1'b0);
      check("bp_hold_tag", bus.rsp_tag, 4'h3);
      tick();
      check("bp_fifth_valid", bus.rsp_valid, 1'b1);
      check("bp_fifth_tag",   bus.rsp_tag, 4'h4);
      check("bp_fifth_y",     bus.rsp_y, 8'h14);
      check("bp_fifth_flags", bus.rsp_flags, 5'b00001);
      check("bp_fifth_cnt",   op_cnt, 16'd6);
      tick();
      bus.rsp_ready = 1'b0;
      check("bp_drained", bus.rsp_valid, 1'b0);

      // Sticky overflow: 0x70 + 0x70 = 0xE0 overflows
      run_op(8'h70, 8'h70, 2'd0, 4'h5);
      check("st_set",   sticky_ovf, 1'b1);
      check("st_y",     bus.rsp_y, 8'hE0);
      check("st_flags", bus.rsp_flags, 5'b11010);
      check("st_cnt",   op_cnt, 16'd7);
      pop_one();
      send(8'h70, 8'h70, 2'd0, 4'h6);
      tick();
      tick();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("st_set_wins", sticky_ovf, 1'b1);
      check("st_cnt2",     op_cnt, 16'd8);
      pop_one();

      // Subtraction with signed overflow, then a logic op
      run_op(8'h80, 8'h01, 2'd1, 4'h7);
      check("sub_y",     bus.rsp_y, 8'h7F);
      check("sub_flags", bus.rsp_flags, 5'b11100);
      pop_one();
      run_op(8'hF0, 8'h3C, 2'd2, 4'h8);
      check("and_y",     bus.rsp_y, 8'h30);
      check("and_flags", bus.rsp_flags, 5'b00100);
      check("and_tag",   bus.rsp_tag, 4'h8);
      check("and_cnt",   op_cnt, 16'd10);
      pop_one();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("st_cleared", sticky_ovf, 1'b0);

      // Reset in the middle of SETTLE discards the request
      send(8'h22, 8'h33, 2'd0, 4'h9);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_busy",   busy, 1'b0);
      check("mr_alu_a",  bus.alu_a, 8'h00);
      check("mr_op_cnt", op_cnt, 16'd0);
      check("mr_rsp",    bus.rsp_valid, 1'b0);
      #2;
      rst_n = 1'b1;
      repeat (5) tick();
      check("mr_no_rsp",  bus.rsp_valid, 1'b0);
      check("mr_cnt_0",   op_cnt, 16'd0);
      check("mr_alu_a_0", bus.alu_a, 8'h00);

`ifdef ALU_CHECK_EN
      run_op(8'h03, 8'h04, 2'd0, 4'h1);
      check("chk_clean", chk_err, 1'b0);
      pop_one();
      force_bad = 1'b1;
      run_op(8'h03, 8'h03, 2'd0, 4'h2);
      force_bad = 1'b0;
      check("chk_flagged", chk_err, 1'b1);
      pop_one();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("chk_cleared", chk_err, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
